// File: rtl/instr_queue.sv
// Instruction queue between fetch and decode: a DEPTH-entry FIFO of
// {instruction, pc} pairs with the head word decoded into MIPS fields.
module instr_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic [5:0]       opcode,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [5:0]       func,
  output logic [15:0]      imm16,
  output logic [25:0]      imm26,
  input  logic             ext_sign,
  output logic [31:0]      imm32,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      instr_mem [DEPTH];
  logic [31:0]      pc_mem    [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push;
  logic             pop;
  logic [31:0]      head_instr;
  logic [31:0]      head_pc;

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; ready never depends on valid of the same port, and a full queue
  // refuses a push even when the head is being popped in that cycle.
  assign in_ready  = (cnt < CNT_W'(DEPTH)) && !reset && !flush;
  assign out_valid = (cnt != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; the out_valid mask below hides stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= in_instr;
      pc_mem[wr_ptr]    <= in_pc;
    end
  end

  assign head_instr = out_valid ? instr_mem[rd_ptr] : 32'h0;
  assign head_pc    = out_valid ? pc_mem[rd_ptr]    : 32'h0;

  assign out_instr = head_instr;
  assign out_pc    = head_pc;
  assign opcode    = head_instr[31:26];
  assign rs        = head_instr[25:21];
  assign rt        = head_instr[20:16];
  assign rd        = head_instr[15:11];
  assign shamt     = head_instr[10:6];
  assign func      = head_instr[5:0];
  assign imm16     = head_instr[15:0];
  assign imm26     = head_instr[25:0];
  assign imm32     = {{16{ext_sign & head_instr[15]}}, head_instr[15:0]};
  assign count     = cnt;

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of instruction entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter CNT_W, default $clog2(DEPTH)+1, width of the count output.
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  producer offers an entry this cycle.
REQ-006 in_ready  output  1  queue can accept an entry this cycle.
REQ-007 in_instr  input  32  MIPS instruction word offered.
REQ-008 in_pc  input  32  PC of the offered instruction.
REQ-009 flush  input  1  discard all entries (branch/exception redirect).
REQ-010 out_ready  input  1  consumer takes the head entry this cycle.
REQ-011 out_valid  output  1  head entry is present.
REQ-012 out_instr, out_pc  output  32 each  head instruction word and its PC.
REQ-013 opcode 6, rs 5, rt 5, rd 5, shamt 5, func 6, imm16 16, imm26 26  outputs  fields of the head instruction.
REQ-014 ext_sign  input  1  1 = sign-extend imm16, 0 = zero-extend imm16.
REQ-015 imm32  output  32  imm16 extended according to ext_sign.
REQ-016 count  output  CNT_W  number of stored entries.

Function
REQ-017 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-018 in_ready SHALL equal (count < DEPTH) && !reset && !flush; a full queue SHALL NOT accept a push, even in a cycle with a pop.
REQ-019 out_valid SHALL equal (count != 0).
REQ-020 A pushed entry SHALL appear at the head no earlier than the cycle after the push; there is no combinational input-to-output bypass.
REQ-021 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-022 Write and read pointers SHALL wrap from DEPTH-1 to 0.
REQ-023 Field outputs SHALL be combinational slices of the head word: opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], func=[5:0], imm16=[15:0], imm26=[25:0].
REQ-024 imm32 SHALL be {16{imm16[15]}, imm16} when ext_sign=1 and {16'b0, imm16} when ext_sign=0; ext_sign SHALL take effect combinationally.
REQ-025 When out_valid=0, out_instr, out_pc, every field output and imm32 SHALL be 0 (decodes as nop).
REQ-026 flush SHALL empty the queue at the next edge (count=0, pointers=0); any push or pop in the same cycle SHALL be ignored.
REQ-027 count SHALL never exceed DEPTH or go below 0.

Reset
REQ-028 When reset=1 at a rising edge: count=0, both pointers=0; out_valid=0 and all data outputs=0 from that edge.
REQ-029 reset SHALL take priority over flush, push and pop; a reset asserted mid-stream SHALL discard all stored entries.
REQ-030 Storage array contents need not be cleared by reset; REQ-025 masks them.

Verification
REQ-031 After reset, push 0x00851021 at PC 0x00003000, out_ready=0 -> next cycle out_valid=1, opcode=0, rs=4, rt=5, rd=2, shamt=0, func=0x21, out_pc=0x00003000, count=1.
REQ-032 Head 0x2402FFFF -> opcode=0x09, rt=2, imm16=0xFFFF; imm32=0xFFFFFFFF with ext_sign=1 and 0x0000FFFF with ext_sign=0, in the same cycle.
REQ-033 DEPTH=4: push 5 entries back-to-back with out_ready=0 -> in_ready=0 after the 4th push, count=4, 5th entry not stored; then pop all four -> PCs emerge in push order, out_valid=0 and outputs 0 afterwards.
REQ-034 Queue at count=2, push and pop in the same cycle for 8 cycles -> count stays 2, pointers wrap, order preserved across the wrap.
REQ-035 count=3, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, pushed entry discarded; a push in the following cycle is accepted normally.
REQ-036 count=2, assert reset with in_valid=1 -> next cycle count=0, out_valid=0, in_ready=0 during the reset cycle and 1 once reset drops.
